// File: rtl/apa102_pkg.sv
// Shared types and constants for the APA102 LED-string receiver.
package apa102_pkg;

  typedef enum logic {
    ST_HUNT  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ZRUN_W    = 6;
  localparam int unsigned BITCNT_W  = 5;
  localparam int unsigned COUNT_W   = 9;
  localparam int unsigned INDEX_W   = 8;
  localparam int unsigned ZRUN_START = 32;
  localparam int unsigned COUNT_MAX  = 511;
  localparam int unsigned INDEX_MAX  = 255;

  localparam logic [WORD_W-1:0] START_WORD = 32'h0000_0000;
  localparam logic [WORD_W-1:0] END_WORD   = 32'hFFFF_FFFF;
  localparam logic [2:0]        LED_HDR    = 3'b111;

  localparam int unsigned HDR_MSB    = 31;
  localparam int unsigned HDR_LSB    = 29;
  localparam int unsigned BRIGHT_MSB = 28;
  localparam int unsigned BRIGHT_LSB = 24;
  localparam int unsigned BLUE_MSB   = 23;
  localparam int unsigned BLUE_LSB   = 16;
  localparam int unsigned GREEN_MSB  = 15;
  localparam int unsigned GREEN_LSB  = 8;
  localparam int unsigned RED_MSB    = 7;
  localparam int unsigned RED_LSB    = 0;

  typedef struct packed {
    logic [4:0] bright;
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
  } led_fields_t;

endpackage

// File: rtl/apa102_sync.sv
// Two-flop synchronizer for one asynchronous input bit.
module apa102_sync (
  input  logic CLK,
  input  logic myreset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or negedge myreset_n) begin
    if (!myreset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/apa102_rx.sv
// APA102 LED-string receiver: frames the sck/mosi bit stream and reports
// decoded LED words plus frame start/end/error events.
module apa102_rx
  import apa102_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 myreset_n,
  input  logic                 sck,
  input  logic                 mosi,
  output logic                 led_valid,
  output logic [4:0]           led_bright,
  output logic [7:0]           led_blue,
  output logic [7:0]           led_green,
  output logic [7:0]           led_red,
  output logic [INDEX_W-1:0]   led_index,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 frame_error,
  output logic [COUNT_W-1:0]   led_count
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic sck_s2, mosi_s2, sck_s3, sck_rise;

  apa102_sync u_sync_sck  (.CLK(CLK), .myreset_n(myreset_n), .d(sck),  .q(sck_s2));
  apa102_sync u_sync_mosi (.CLK(CLK), .myreset_n(myreset_n), .d(mosi), .q(mosi_s2));

  state_t                state_q, state_nxt;
  logic [ZRUN_W-1:0]     zrun_q, zrun_nxt;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_nxt;
  // The 32nd bit joins the word combinationally, so only 31 bits are held.
  logic [WORD_W-2:0]     shift_q, shift_nxt;
  logic [IDLE_W-1:0]     idle_q, idle_nxt;
  led_fields_t           fields_q, fields_nxt;
  logic [INDEX_W-1:0]    index_q, index_nxt;
  logic [COUNT_W-1:0]    count_q, count_nxt;
  logic                  valid_q, valid_nxt;
  logic                  start_q, start_nxt;
  logic                  end_q, end_nxt;
  logic                  err_q, err_nxt;
  logic [WORD_W-1:0]     word;

  assign sck_rise = sck_s2 & ~sck_s3;
  assign word     = {shift_q, mosi_s2};

  always_ff @(posedge CLK or negedge myreset_n) begin
    if (!myreset_n) begin
      sck_s3   <= 1'b0;
      state_q  <= ST_HUNT;
      zrun_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      idle_q   <= '0;
      fields_q <= '0;
      index_q  <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sck_s3   <= sck_s2;
      state_q  <= state_nxt;
      zrun_q   <= zrun_nxt;
      bitcnt_q <= bitcnt_nxt;
      shift_q  <= shift_nxt;
      idle_q   <= idle_nxt;
      fields_q <= fields_nxt;
      index_q  <= index_nxt;
      count_q  <= count_nxt;
      valid_q  <= valid_nxt;
      start_q  <= start_nxt;
      end_q    <= end_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    zrun_nxt   = zrun_q;
    bitcnt_nxt = bitcnt_q;
    shift_nxt  = shift_q;
    idle_nxt   = idle_q;
    fields_nxt = fields_q;
    index_nxt  = index_q;
    count_nxt  = count_q;
    valid_nxt  = 1'b0;
    start_nxt  = 1'b0;
    end_nxt    = 1'b0;
    err_nxt    = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (sck_rise) begin
          if (mosi_s2) begin
            zrun_nxt = '0;
          end else if (zrun_q == ZRUN_W'(ZRUN_START - 1)) begin
            start_nxt  = 1'b1;
            count_nxt  = '0;
            bitcnt_nxt = '0;
            zrun_nxt   = '0;
            idle_nxt   = '0;
            state_nxt  = ST_FRAME;
          end else begin
            zrun_nxt = zrun_q + ZRUN_W'(1);
          end
        end
      end

      ST_FRAME: begin
        if (sck_rise) begin
          shift_nxt  = word[WORD_W-2:0];
          bitcnt_nxt = bitcnt_q + BITCNT_W'(1);
          idle_nxt   = '0;
          if (bitcnt_q == '1) begin
            if (word == START_WORD) begin
              start_nxt = 1'b1;
              count_nxt = '0;
            end else if (word == END_WORD) begin
              end_nxt   = 1'b1;
              zrun_nxt  = '0;
              state_nxt = ST_HUNT;
            end else if (word[HDR_MSB:HDR_LSB] == LED_HDR) begin
              valid_nxt         = 1'b1;
              fields_nxt.bright = word[BRIGHT_MSB:BRIGHT_LSB];
              fields_nxt.blue   = word[BLUE_MSB:BLUE_LSB];
              fields_nxt.green  = word[GREEN_MSB:GREEN_LSB];
              fields_nxt.red    = word[RED_MSB:RED_LSB];
              index_nxt = (count_q > COUNT_W'(INDEX_MAX)) ? INDEX_W'(INDEX_MAX)
                                                          : INDEX_W'(count_q);
              if (count_q != COUNT_W'(COUNT_MAX)) count_nxt = count_q + COUNT_W'(1);
            end else begin
              err_nxt   = 1'b1;
              zrun_nxt  = '0;
              state_nxt = ST_HUNT;
            end
          end
        end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          // Silence on sck: drop the frame, flagging it only if a word was cut short.
          err_nxt   = (bitcnt_q != '0);
          zrun_nxt  = '0;
          idle_nxt  = '0;
          state_nxt = ST_HUNT;
        end else begin
          idle_nxt = idle_q + IDLE_W'(1);
        end
      end

      default: state_nxt = ST_HUNT;
    endcase
  end

  assign led_valid   = valid_q;
  assign led_bright  = fields_q.bright;
  assign led_blue    = fields_q.blue;
  assign led_green   = fields_q.green;
  assign led_red     = fields_q.red;
  assign led_index   = index_q;
  assign led_count   = count_q;
  assign frame_start = start_q;
  assign frame_end   = end_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_apa102_rx.sv
// Self-checking bench for apa102_rx: table vectors, directed corner cases,
// and randomized frames against a word-level reference model.
module tb_apa102_rx;

  logic       CLK = 1'b0;
  logic       myreset_n = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       led_valid, frame_start, frame_end, frame_error;
  logic [4:0] led_bright;
  logic [7:0] led_blue, led_green, led_red, led_index;
  logic [8:0] led_count;

  always #5 CLK = ~CLK;

  apa102_rx #(.TIMEOUT_CYCLES(1024)) dut (
    .CLK(CLK), .myreset_n(myreset_n), .sck(sck), .mosi(mosi),
    .led_valid(led_valid), .led_bright(led_bright), .led_blue(led_blue),
    .led_green(led_green), .led_red(led_red), .led_index(led_index),
    .frame_start(frame_start), .frame_end(frame_end), .frame_error(frame_error),
    .led_count(led_count)
  );

  typedef enum int {EV_VALID, EV_START, EV_END, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [4:0] bright;
    logic [7:0] blue, green, red, index;
    logic [8:0] count;
  } ev_t;
  typedef struct {
    logic [31:0] word;
    ev_t         exp;
  } vec_t;

  ev_t evq[$];
  int  errors = 0;
  int  checks = 0;

  // Event capture: every output pulse becomes one queue entry.
  always @(negedge CLK) begin
    ev_t e;
    e.bright = led_bright; e.blue = led_blue; e.green = led_green; e.red = led_red;
    e.index = led_index; e.count = led_count;
    if (led_valid)   begin e.kind = EV_VALID; evq.push_back(e); end
    if (frame_start) begin e.kind = EV_START; evq.push_back(e); end
    if (frame_end)   begin e.kind = EV_END;   evq.push_back(e); end
    if (frame_error) begin e.kind = EV_ERR;   evq.push_back(e); end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(ev_kind_t k, logic [31:0] w, int idx, int cnt);
    ev_t e;
    e.kind = k; e.bright = w[28:24]; e.blue = w[23:16]; e.green = w[15:8]; e.red = w[7:0];
    e.index = 8'(idx); e.count = 9'(cnt);
    return e;
  endfunction

  function automatic bit ev_match(ev_t a, ev_t e);
    if (a.kind != e.kind) return 1'b0;
    if (e.kind == EV_VALID)
      return (a.bright == e.bright) && (a.blue == e.blue) && (a.green == e.green) &&
             (a.red == e.red) && (a.index == e.index);
    if (e.kind == EV_START || e.kind == EV_END) return a.count == e.count;
    return 1'b1;
  endfunction

  task automatic check_evt(input string nm, input ev_t e);
    ev_t a;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL %s: no event, required kind=%0d idx=%0d cnt=%0d", nm, e.kind, e.index, e.count);
    end else begin
      a = evq.pop_front();
      if (!ev_match(a, e)) begin
        errors++;
        $display("FAIL %s: got kind=%0d br=%0d b=%h g=%h r=%h idx=%0d cnt=%0d, required kind=%0d br=%0d b=%h g=%h r=%h idx=%0d cnt=%0d",
                 nm, a.kind, a.bright, a.blue, a.green, a.red, a.index, a.count,
                 e.kind, e.bright, e.blue, e.green, e.red, e.index, e.count);
      end
    end
  endtask

  task automatic check_none(input string nm);
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d unexpected events, first kind=%0d", nm, evq.size(), evq[0].kind);
      evq.delete();
    end
  endtask

  task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // One bit at the minimum 3/3 CLK sck duty, mosi changing at a random low-phase point.
  task automatic send_bit(input logic b);
    int pre;
    pre = $urandom_range(0, 2);
    repeat (pre) @(negedge CLK);
    #($urandom_range(0, 3));
    mosi = b;
    repeat (3 - pre) @(negedge CLK);
    sck = 1'b1;
    repeat (3) @(negedge CLK);
    sck = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int msb, input int lsb);
    for (int i = msb; i >= lsb; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 31, 0);
    repeat (2) @(negedge CLK);
  endtask

  function automatic logic [31:0] rand_led();
    logic [31:0] w;
    w = {3'b111, 29'($urandom)};
    if (w == 32'hFFFF_FFFF) w[0] = 1'b0;
    return w;
  endfunction

  // Word-level reference: frame rules applied to whole words.
  task automatic model_frame(input logic [31:0] ws[$], output ev_t exq[$]);
    bit in_frame;
    int cnt;
    in_frame = 0; cnt = 0; exq.delete();
    foreach (ws[i]) begin
      if (!in_frame) begin
        if (ws[i] == 32'h0) begin in_frame = 1; cnt = 0; exq.push_back(mk(EV_START, 0, 0, 0)); end
      end else if (ws[i] == 32'h0) begin
        cnt = 0; exq.push_back(mk(EV_START, 0, 0, 0));
      end else if (ws[i] == 32'hFFFF_FFFF) begin
        in_frame = 0; exq.push_back(mk(EV_END, 0, 0, cnt));
      end else if (ws[i][31:29] == 3'b111) begin
        exq.push_back(mk(EV_VALID, ws[i], (cnt > 255) ? 255 : cnt, 0));
        cnt = (cnt >= 511) ? 511 : cnt + 1;
      end else begin
        in_frame = 0; exq.push_back(mk(EV_ERR, 0, 0, 0));
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    logic [31:0] ws[$];
    ev_t         exq[$];
    logic [31:0] w;
    int          n;
    bit          seen;

    tbl[0] = '{32'h0000_0000, '{EV_START, 5'd0,  8'h00, 8'h00, 8'h00, 8'd0, 9'd0}};
    tbl[1] = '{32'hE510_2030, '{EV_VALID, 5'd5,  8'h10, 8'h20, 8'h30, 8'd0, 9'd0}};
    tbl[2] = '{32'hFFAA_BBCC, '{EV_VALID, 5'd31, 8'hAA, 8'hBB, 8'hCC, 8'd1, 9'd0}};
    tbl[3] = '{32'h0000_0000, '{EV_START, 5'd0,  8'h00, 8'h00, 8'h00, 8'd0, 9'd0}};
    tbl[4] = '{32'hE000_0001, '{EV_VALID, 5'd0,  8'h00, 8'h00, 8'h01, 8'd0, 9'd0}};
    tbl[5] = '{32'hFFFF_FFFF, '{EV_END,   5'd0,  8'h00, 8'h00, 8'h00, 8'd0, 9'd1}};

    repeat (3) @(negedge CLK);
    check_eq("reset_outputs", 64'({led_valid, frame_start, frame_end, frame_error, led_bright,
             led_blue, led_green, led_red, led_index, led_count}), 64'h0);
    myreset_n = 1'b1;
    repeat (3) @(negedge CLK);

    // Table: start, LEDs, repeated start, LED, end.
    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].word);
      check_evt($sformatf("tbl[%0d]", i), tbl[i].exp);
    end
    check_none("tbl_extra");

    // Latency from the final sck rise at the pin.
    send_word(32'h0);
    check_evt("lat_start", mk(EV_START, 0, 0, 0));
    send_bits(32'hE510_2030, 31, 1);
    repeat (3) @(negedge CLK);
    mosi = 1'b0;
    sck = 1'b1;
    n = 0; seen = 0;
    while (n < 10 && !seen) begin
      @(negedge CLK);
      n++;
      if (led_valid) seen = 1;
    end
    check_eq("lat_cycles_le4", 64'(seen && n <= 4), 64'd1);
    repeat (3) @(negedge CLK);
    sck = 1'b0;
    check_evt("lat_valid", mk(EV_VALID, 32'hE510_2030, 0, 0));
    send_word(32'hFFFF_FFFF);
    check_evt("lat_end", mk(EV_END, 0, 0, 1));

    // Bad header aborts; LED words are ignored until 32 zeros.
    send_word(32'h0);
    check_evt("err_start", mk(EV_START, 0, 0, 0));
    send_word(32'h4012_3456);
    check_evt("err_word", mk(EV_ERR, 0, 0, 0));
    send_word(32'hE100_00FF);
    send_word(32'hE200_00FF);
    check_none("err_ignored");
    send_word(32'h0);
    check_evt("err_restart", mk(EV_START, 0, 0, 0));
    send_word(32'hE300_00FF);
    check_evt("err_led0", mk(EV_VALID, 32'hE300_00FF, 0, 0));
    send_word(32'hFFFF_FFFF);
    check_evt("err_end", mk(EV_END, 0, 0, 1));

    // Timeout with a partial word flags an error; after a complete word it does not.
    send_word(32'h0);
    check_evt("to_start", mk(EV_START, 0, 0, 0));
    send_bits(32'hE510_2030, 31, 15);
    repeat (1000) @(negedge CLK);
    check_none("to_not_early");
    repeat (100) @(negedge CLK);
    check_evt("to_partial_err", mk(EV_ERR, 0, 0, 0));
    check_none("to_err_once");
    send_word(32'hE400_00FF);
    check_none("to_in_hunt");
    send_word(32'h0);
    check_evt("to2_start", mk(EV_START, 0, 0, 0));
    send_word(32'hE500_00FF);
    check_evt("to2_valid", mk(EV_VALID, 32'hE500_00FF, 0, 0));
    repeat (1100) @(negedge CLK);
    check_none("to2_no_err");
    send_word(32'hE600_00FF);
    check_none("to2_in_hunt");

    // Reset in the middle of a word.
    send_word(32'h0);
    check_evt("rst_start", mk(EV_START, 0, 0, 0));
    send_word(32'hE7AA_BBCC);
    check_evt("rst_led", mk(EV_VALID, 32'hE7AA_BBCC, 0, 0));
    send_bits(32'hE123_4567, 31, 22);
    myreset_n = 1'b0;
    #1;
    check_eq("rst_outputs", 64'({led_valid, frame_start, frame_end, frame_error, led_bright,
             led_blue, led_green, led_red, led_index, led_count}), 64'h0);
    repeat (3) @(negedge CLK);
    myreset_n = 1'b1;
    evq.delete();
    send_bits(32'hE123_4567, 21, 0);
    repeat (2) @(negedge CLK);
    check_none("rst_partial_discarded");
    send_word(32'h0);
    check_evt("rst_restart", mk(EV_START, 0, 0, 0));
    send_word(32'hE811_2233);
    check_evt("rst_led0", mk(EV_VALID, 32'hE811_2233, 0, 0));
    send_word(32'hFFFF_FFFF);
    check_evt("rst_end", mk(EV_END, 0, 0, 1));

    // 300 LEDs: index saturates at 255, count reaches 300.
    send_word(32'h0);
    check_evt("sat_start", mk(EV_START, 0, 0, 0));
    for (int i = 0; i < 300; i++) begin
      w = {3'b111, 5'(i), 8'(i >> 8), 8'(i), 8'(~i)};
      send_word(w);
      check_evt($sformatf("sat_led[%0d]", i), mk(EV_VALID, w, (i > 255) ? 255 : i, 0));
    end
    send_word(32'hFFFF_FFFF);
    check_evt("sat_end", mk(EV_END, 0, 0, 300));

    // Randomized frames against the word-level model.
    for (int f = 0; f < 8; f++) begin
      bit aborted;
      ws.delete();
      ws.push_back(32'h0);
      aborted = 0;
      for (int j = $urandom_range(1, 4); j > 0 && !aborted; j--) begin
        case ($urandom_range(0, 9))
          7: ws.push_back(32'h0);
          8: begin
            w = {3'($urandom_range(0, 6)), 29'($urandom)};
            if (w == 32'h0) w[0] = 1'b1;
            ws.push_back(w);
            aborted = 1;
          end
          default: ws.push_back(rand_led());
        endcase
      end
      if (!aborted) ws.push_back(32'hFFFF_FFFF);
      model_frame(ws, exq);
      foreach (ws[i]) send_word(ws[i]);
      foreach (exq[i]) check_evt($sformatf("rnd[%0d].%0d", f, i), exq[i]);
      check_none($sformatf("rnd[%0d]_extra", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
